sync_fifo_ctrl: RTL
===================

Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO that succeeds the dual-clock async FIFO, keeping the same winc/rinc/wfull/rempty protocol. Adds a fill count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. Illegal pushes and pops are reported, not forbidden. Used where producer and consumer share a clock, and as a formal target for the protocol checks the team already runs on the async FIFO.

Parameters:
DATA_WIDTH, 8, width of each entry
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 by default)
AFULL_THRESH, 14, walmost_full asserted when count >= AFULL_THRESH; legal range 1..DEPTH
AEMPTY_THRESH, 2, ralmost_empty asserted when count <= AEMPTY_THRESH; legal range 0..DEPTH-1

Ports:
clk  input  1  single clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
winc  input  1  push request
wdata  input  DATA_WIDTH  push data, sampled on a posedge with winc=1
wfull  output  1  count == DEPTH
walmost_full  output  1  count >= AFULL_THRESH
rinc  input  1  pop request
rdata  output  DATA_WIDTH  read data
rempty  output  1  count == 0
ralmost_empty  output  1  count <= AEMPTY_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky; a push was attempted while full
underflow  output  1  sticky; a pop was attempted while empty
clr_err  input  1  synchronous clear of overflow and underflow

Behaviour:
- Reset (rst_n=0, asynchronous): wptr=rptr=0, count=0, rdata=0, overflow=underflow=0. Outputs are rempty=1, ralmost_empty=1, wfull=0, walmost_full=0. Memory contents are not reset.
- Pointers are ADDR_WIDTH+1 bits wide: the low bits address the memory and the MSB is the wrap bit. Pointers wrap from 2*DEPTH-1 to 0.
- All flags and count are decoded from registered state. A change is visible in the cycle after the causing edge; there is no combinational path from winc/rinc to any flag.
- push_ok = winc & (!wfull | rinc). On push_ok, mem[wptr] <= wdata and wptr increments.
- pop_ok = rinc & !rempty. On pop_ok, rdata <= mem[rptr] and rptr increments. Read latency is 1 cycle. rdata holds its value when there is no pop.
- Simultaneous winc and rinc:
  - When full: both are accepted, count is unchanged, and overflow is not set.
  - When empty: the push is accepted, the pop is rejected, count becomes 1, and underflow is set. A new entry is never read in the cycle it is written.
  - Otherwise: both are accepted and count is unchanged.
- count: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither occur.
- overflow <= 1 when winc & wfull & !rinc. A rejected push leaves memory, wptr and count untouched.
- underflow <= 1 when rinc & rempty. A rejected pop leaves rdata and rptr untouched.
- clr_err clears both sticky flags. A new error detected in the same cycle as clr_err has priority, so the flag remains 1.
- Reset asserted mid-operation discards all contents immediately, regardless of clk.
- Required invariants for formal: wfull and rempty are never both 1; count == wptr - rptr (modulo 2*DEPTH).

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN (first-word fall-through).
- Defined: rdata = mem[rptr] combinationally whenever !rempty, so the head entry is visible without a pop. rinc acknowledges the head and advances rptr. The first word is visible the cycle after the push that made the FIFO non-empty. rdata is don't-care while rempty=1.
- Undefined: the registered 1-cycle-latency rdata described in Behaviour.
- All flags, count and error logic are identical in both modes.

Test Plan:
1. Reset, then push 0x01..0x10 (16 words) -> wfull=1 and count=16 after the last push. walmost_full rises the cycle after the 14th push.
2. Pop all 16 -> rdata sequence is 0x01..0x10, each one cycle after its pop. rempty=1 after the last pop. ralmost_empty rises when count=2.
3. With the FIFO full, winc=1 with wdata=0xAA and rinc=0 -> overflow=1, count stays 16. A full drain does not return 0xAA.
4. With the FIFO full, winc=rinc=1 with wdata=0x55 -> count stays 16, overflow=0, and 0x55 is the last word read on drain.
5. With the FIFO empty, winc=rinc=1 with wdata=0x33 -> count=1, underflow=1, rdata unchanged. Then clr_err=1 -> underflow=0 the next cycle.
6. Push 40 words interleaved with pops (pointer wrap, >2*DEPTH) -> data order is preserved and count matches the scoreboard each cycle. Assert rst_n mid-burst -> count=0 and rempty=1 immediately.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl
//   Single-clock FIFO controller with fill count, almost-full/almost-empty
//   thresholds and sticky overflow/underflow flags. It uses the same
//   winc/rinc/wfull/rempty handshake as the dual-clock FIFO it replaces.
//   Illegal pushes and pops are rejected and reported through the sticky
//   flags; they never corrupt state.
//
// Optional feature:
//   SYNC_FIFO_FWFT_EN  first-word fall-through. The head entry drives rdata
//                      combinationally while the FIFO is non-empty. When the
//                      macro is undefined, rdata is registered and appears one
//                      cycle after the pop.
//
// Ports:
//   clk            single clock, posedge
//   rst_n          asynchronous active-low reset
//   winc / wdata   push request and data
//   wfull          count == DEPTH
//   walmost_full   count >= AFULL_THRESH
//   rinc / rdata   pop request and read data
//   rempty         count == 0
//   ralmost_empty  count <= AEMPTY_THRESH
//   count          occupancy, 0..DEPTH
//   overflow       sticky: push attempted while full (no simultaneous pop)
//   underflow      sticky: pop attempted while empty
//   clr_err        synchronous clear of both sticky flags

module sync_fifo_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = 14,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wfull,
  output logic                  walmost_full,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] CNT_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH:0] rptr_q, rptr_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                underflow_q, underflow_d;

  logic                push_ok;
  logic                pop_ok;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;

  assign waddr = wptr_q[ADDR_WIDTH-1:0];
  assign raddr = rptr_q[ADDR_WIDTH-1:0];

  // All flags decode registered count only, so no combinational path exists
  // from winc/rinc to any status output.
  assign wfull         = (count_q == CNT_FULL);
  assign rempty        = (count_q == '0);
  assign walmost_full  = (count_q >= AFULL_LVL);
  assign ralmost_empty = (count_q <= AEMPTY_LVL);
  assign count         = count_q;
  assign overflow      = overflow_q;
  assign underflow     = underflow_q;

  // A push while full is still legal when a pop frees the head slot in the
  // same cycle. A pop while empty is always rejected, so a freshly written
  // entry is never read in its write cycle.
  assign push_ok = winc & (~wfull | rinc);
  assign pop_ok  = rinc & ~rempty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (push_ok) wptr_d = wptr_q + PTR_ONE;
    if (pop_ok)  rptr_d = rptr_q + PTR_ONE;

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase

    // Clear first so an error detected in the same cycle wins.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (winc & wfull & ~rinc) overflow_d  = 1'b1;
    if (rinc & rempty)        underflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[waddr] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry falls through; the value is meaningless while rempty is set.
  assign rdata = mem_q[raddr];
`else
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (pop_ok) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
`endif

endmodule
